pixel_frequency_monitor: RTL

Parametrised multi-channel successor to the three-pixel frequency analyzer manager. It takes a single-clock pixel stream and, for each of CHANNELS configured pixel positions, samples one data bit per frame. It measures the clock-cycle period between rising edges of that bit and accumulates "action time" for two target frequencies per channel. On stop it drains all 2×CHANNELS accumulators through the register-write interface of the AXI slave with a ready handshake, then raises irq.

---
 rtl/pixel_frequency_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pixel_frequency_monitor.sv
// Samples one data bit per frame at each channel's pixel, measures rising-edge periods and accumulates
// time in two frequency windows per channel; on stop drains 2*CHANNELS slots (one per ready cycle), then pulses irq.
module pixel_frequency_monitor #(
  parameter int CHANNELS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLE_BIT = 7,
  parameter int PIXEL_INDEX_WIDTH = 10,
  parameter logic [CHANNELS*PIXEL_INDEX_WIDTH-1:0] PIXEL_INDICES = {10'd1023, 10'd511, 10'd63},
  parameter logic [CHANNELS*64-1:0] FREQUENCIES =
    {32'd30000, 32'd25000, 32'd20000, 32'd15000, 32'd10000, 32'd5000},
  parameter int unsigned FREQUENCY_DEVIATION = 20,
  parameter int unsigned CLOCK_FREQUENCY = 100000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  output logic [1:0]            register_operation,
  output logic [7:0]            register_number,
  output logic [31:0]           register_write,
  input  logic                  register_ready,
  output logic                  irq,
  output logic [1:0]            state
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SLOTS = 2 * CHANNELS;
  localparam logic [7:0] LAST_SLOT = 8'(SLOTS);

  state_t              state_q, state_d;
  logic [7:0]          slot_q;
  logic [SLOTS*32-1:0] acc_bus;
  logic                enter_run, running, accept, last_accept, clear_ok;
  logic                unused_data;

  assign enter_run   = (state_q == ST_IDLE || state_q == ST_DONE) && start;
  assign running     = state_q == ST_RUN;
  assign accept      = state_q == ST_DRAIN && register_ready;
  assign last_accept = accept && slot_q == LAST_SLOT;
  assign clear_ok    = clear && state_q != ST_DRAIN;
  assign unused_data = ^data;
  assign state       = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (stop) state_d = ST_DRAIN;
      ST_DRAIN:         if (last_accept) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Slot pointer is re-armed on every stop, so a drain cut short by reset restarts at slot 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= 8'd0;
      irq    <= 1'b0;
    end else begin
      irq <= last_accept;
      if (running && stop)  slot_q <= 8'd1;
      else if (accept)      slot_q <= last_accept ? 8'd0 : slot_q + 8'd1;
    end
  end

  always_comb begin
    register_operation = 2'd0;
    register_number    = 8'd0;
    register_write     = 32'd0;
    if (state_q == ST_DRAIN) begin
      register_operation = 2'd2;
      register_number    = slot_q;
      for (int i = 0; i < SLOTS; i++) begin
        if (slot_q == 8'(i + 1)) register_write = acc_bus[i*32 +: 32];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    localparam logic [PIXEL_INDEX_WIDTH-1:0] INDEX =
      PIXEL_INDICES[c*PIXEL_INDEX_WIDTH +: PIXEL_INDEX_WIDTH];
    localparam logic [63:0] P0  = 64'(CLOCK_FREQUENCY) / 64'(FREQUENCIES[(2*c)*32 +: 32]);
    localparam logic [63:0] P1  = 64'(CLOCK_FREQUENCY) / 64'(FREQUENCIES[(2*c+1)*32 +: 32]);
    localparam logic [63:0] D0  = (P0 * 64'(FREQUENCY_DEVIATION)) / 64'd100;
    localparam logic [63:0] D1  = (P1 * 64'(FREQUENCY_DEVIATION)) / 64'd100;
    localparam logic [63:0] LO0 = P0 - D0;
    localparam logic [63:0] HI0 = P0 + D0;
    localparam logic [63:0] LO1 = P1 - D1;
    localparam logic [63:0] HI1 = P1 + D1;

    logic [PIXEL_INDEX_WIDTH-1:0] pixel_count, pixel_number;
    logic                         sample, sample_prev, armed, rising;
    logic                         in_window0, in_window1;
    logic [31:0]                  period, acc0, acc1;
    logic [32:0]                  sum0, sum1;
    logic [63:0]                  elapsed;

    assign pixel_number = frame_start ? '0 : pixel_count;
    assign rising       = sample && !sample_prev;
    assign elapsed      = {32'd0, period};
    assign in_window0   = elapsed >= LO0 && elapsed <= HI0;
    assign in_window1   = elapsed >= LO1 && elapsed <= HI1;
    assign sum0         = {1'b0, acc0} + {1'b0, period};
    assign sum1         = {1'b0, acc1} + {1'b0, period};

    always_ff @(posedge clock) begin
      if (reset || enter_run) begin
        pixel_count <= '0;
        sample      <= 1'b0;
        sample_prev <= 1'b0;
        armed       <= 1'b0;
        period      <= 32'd0;
      end else if (running) begin
        if (pixel_valid)
          pixel_count <= frame_start ? PIXEL_INDEX_WIDTH'(1) : pixel_count + PIXEL_INDEX_WIDTH'(1);
        if (pixel_valid && pixel_number == INDEX) sample <= data[SAMPLE_BIT];
        sample_prev <= sample;
        if (rising) begin
          period <= 32'd1;
          armed  <= 1'b1;
        end else if (period != '1) begin
          period <= period + 32'd1;
        end
      end
    end

    // Clear outranks a coincident accumulate; overlapping windows resolve to target 0.
    always_ff @(posedge clock) begin
      if (reset || clear_ok) begin
        acc0 <= 32'd0;
        acc1 <= 32'd0;
      end else if (running && rising && armed) begin
        if (in_window0)      acc0 <= sum0[32] ? '1 : sum0[31:0];
        else if (in_window1) acc1 <= sum1[32] ? '1 : sum1[31:0];
      end
    end

    assign acc_bus[(2*c)*32 +: 32]   = acc0;
    assign acc_bus[(2*c+1)*32 +: 32] = acc1;
  end

endmodule
